// File: rtl/audio_mixer_n_if.sv
// Bus bundle for audio_mixer_n: source snapshot inputs, LR clock and buffer-write outputs.
// The mixer connects through the slave modport; the source/buffer side uses master.
interface audio_mixer_n_if #(
    parameter int unsigned NUM_CH          = 5,
    parameter int unsigned SAMPLE_BITS     = 16,
    parameter int unsigned VOLUME_BITS     = 8,
    parameter int unsigned MASTER_VOL_BITS = 4,
    parameter int unsigned BUF_LEN         = 256
);
    localparam int unsigned INDEX_BITS = $clog2(BUF_LEN);

    logic                            lrclk;
    logic [NUM_CH*SAMPLE_BITS-1:0]   ch_sample;
    logic [NUM_CH*VOLUME_BITS-1:0]   ch_vol;
    logic [NUM_CH-1:0]               ch_mute;
    logic [MASTER_VOL_BITS-1:0]      master_vol;
    logic [INDEX_BITS-1:0]           play_index;
    logic                            wr_en;
    logic [INDEX_BITS-1:0]           wr_addr;
    logic [SAMPLE_BITS-1:0]          wr_data;
    logic                            busy;
    logic                            clip;
    logic                            overrun;
    logic [15:0]                     clip_count;

    modport master (
        output lrclk, ch_sample, ch_vol, ch_mute, master_vol, play_index,
        input  wr_en, wr_addr, wr_data, busy, clip, overrun, clip_count
    );

    modport slave (
        input  lrclk, ch_sample, ch_vol, ch_mute, master_vol, play_index,
        output wr_en, wr_addr, wr_data, busy, clip, overrun, clip_count
    );
endinterface

// File: rtl/audio_mixer_n.sv
// N-channel audio mixer: snapshot on lrclk fall, time-shared MAC, master gain, saturate, buffer write.
// Optional clip statistics counter enabled by defining MIXER_CLIP_STATS_EN.
module audio_mixer_n #(
    parameter int unsigned NUM_CH          = 5,
    parameter int unsigned SAMPLE_BITS     = 16,
    parameter int unsigned VOLUME_BITS     = 8,
    parameter int unsigned MASTER_VOL_BITS = 4,
    parameter int unsigned BUF_LEN         = 256
) (
    input  logic             mclk,
    input  logic             rst,
    audio_mixer_n_if.slave   bus
);
    localparam int unsigned INDEX_BITS = $clog2(BUF_LEN);
    localparam int unsigned CNT_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TERM_W     = SAMPLE_BITS + VOLUME_BITS + 1;
    localparam int unsigned ACC_W      = TERM_W + $clog2(NUM_CH);
    localparam int unsigned PROD_W     = ACC_W + MASTER_VOL_BITS + 1;

    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((64'sd1 <<< (SAMPLE_BITS - 1)) - 64'sd1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCALE, S_WRITE} state_t;

    state_t state_q, state_d;

    logic                                  lrclk_q;
    logic                                  fall;
    logic                                  busy;

    logic [NUM_CH-1:0][SAMPLE_BITS-1:0]    snap_sample_q, snap_sample_d;
    logic [NUM_CH-1:0][VOLUME_BITS-1:0]    snap_vol_q, snap_vol_d;
    logic [NUM_CH-1:0]                     snap_mute_q, snap_mute_d;
    logic [MASTER_VOL_BITS-1:0]            snap_mv_q, snap_mv_d;
    logic [INDEX_BITS-1:0]                 snap_idx_q, snap_idx_d;

    logic signed [ACC_W-1:0]               acc_q, acc_d;
    logic [CNT_W-1:0]                      ch_cnt_q, ch_cnt_d;

    logic                                  wr_en_q, wr_en_d;
    logic [INDEX_BITS-1:0]                 wr_addr_q, wr_addr_d;
    logic [SAMPLE_BITS-1:0]                wr_data_q, wr_data_d;
    logic                                  clip_q, clip_d;
    logic                                  overrun_q, overrun_d;

    logic signed [TERM_W-1:0]              term;
    logic signed [PROD_W-1:0]              shifted, gain, prod, mixed;
    logic [SAMPLE_BITS-1:0]                sat_data;
    logic                                  sat_flag;

`ifdef MIXER_CLIP_STATS_EN
    logic [15:0]                           clip_count_q, clip_count_d;
`endif

    assign fall = lrclk_q & ~bus.lrclk;
    assign busy = (state_q != S_IDLE);

    // State register and all datapath flops
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lrclk_q       <= 1'b1;
            snap_sample_q <= '0;
            snap_vol_q    <= '0;
            snap_mute_q   <= '0;
            snap_mv_q     <= '0;
            snap_idx_q    <= '0;
            acc_q         <= '0;
            ch_cnt_q      <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            clip_q        <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef MIXER_CLIP_STATS_EN
            clip_count_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            lrclk_q       <= bus.lrclk;
            snap_sample_q <= snap_sample_d;
            snap_vol_q    <= snap_vol_d;
            snap_mute_q   <= snap_mute_d;
            snap_mv_q     <= snap_mv_d;
            snap_idx_q    <= snap_idx_d;
            acc_q         <= acc_d;
            ch_cnt_q      <= ch_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            clip_q        <= clip_d;
            overrun_q     <= overrun_d;
`ifdef MIXER_CLIP_STATS_EN
            clip_count_q  <= clip_count_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fall) state_d = S_ACCUM;
            S_ACCUM: if (ch_cnt_q == CNT_W'(NUM_CH - 1)) state_d = S_SCALE;
            S_SCALE: state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shared MAC term and the master-gain/saturation path evaluated during SCALE
    always_comb begin
        term = '0;
        if (!snap_mute_q[ch_cnt_q]) begin
            term = $signed(snap_sample_q[ch_cnt_q]) * $signed({1'b0, snap_vol_q[ch_cnt_q]});
        end

        shifted = PROD_W'(acc_q) >>> VOLUME_BITS;
        gain    = $signed(PROD_W'({1'b0, snap_mv_q}) + PROD_W'(1));
        prod    = shifted * gain;
        mixed   = prod >>> MASTER_VOL_BITS;

        sat_flag = 1'b0;
        sat_data = mixed[SAMPLE_BITS-1:0];
        if (mixed > SAT_MAX) begin
            sat_flag = 1'b1;
            sat_data = SAT_MAX[SAMPLE_BITS-1:0];
        end else if (mixed < SAT_MIN) begin
            sat_flag = 1'b1;
            sat_data = SAT_MIN[SAMPLE_BITS-1:0];
        end
    end

    // Output/datapath next values; write results are registered at the end of SCALE
    always_comb begin
        snap_sample_d = snap_sample_q;
        snap_vol_d    = snap_vol_q;
        snap_mute_d   = snap_mute_q;
        snap_mv_d     = snap_mv_q;
        snap_idx_d    = snap_idx_q;
        acc_d         = acc_q;
        ch_cnt_d      = ch_cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        clip_d        = clip_q;
        overrun_d     = overrun_q | (fall & busy);
`ifdef MIXER_CLIP_STATS_EN
        clip_count_d  = clip_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    snap_sample_d = bus.ch_sample;
                    snap_vol_d    = bus.ch_vol;
                    snap_mute_d   = bus.ch_mute;
                    snap_mv_d     = bus.master_vol;
                    snap_idx_d    = bus.play_index;
                    acc_d         = '0;
                    ch_cnt_d      = '0;
                end
            end
            S_ACCUM: begin
                acc_d    = acc_q + ACC_W'(term);
                ch_cnt_d = ch_cnt_q + 1'b1;
            end
            S_SCALE: begin
                wr_en_d   = 1'b1;
                wr_data_d = sat_data;
                clip_d    = sat_flag;
                wr_addr_d = snap_idx_q - 1'b1;
`ifdef MIXER_CLIP_STATS_EN
                if (sat_flag && (clip_count_q != '1)) clip_count_d = clip_count_q + 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.clip    = clip_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = busy;
`ifdef MIXER_CLIP_STATS_EN
    assign bus.clip_count = clip_count_q;
`else
    assign bus.clip_count = '0;
`endif
endmodule

// File: tb/tb_audio_mixer_n.sv
// Self-checking bench for audio_mixer_n: fixed vectors, randomized mixes against an arithmetic model,
// plus snapshot, overrun and mid-mix reset sequences.
module tb_audio_mixer_n;
    localparam int unsigned NCH = 5;
    localparam int unsigned SB  = 16;
    localparam int unsigned VB  = 8;
    localparam int unsigned MVB = 4;
    localparam int unsigned BL  = 256;
`ifdef MIXER_CLIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [NCH-1:0][SB-1:0] s;
        logic [NCH-1:0][VB-1:0] v;
        logic [NCH-1:0]         mute;
        logic [MVB-1:0]         mv;
        logic [7:0]             pidx;
        logic signed [SB-1:0]   exp_data;
        logic                   exp_clip;
    } vec_t;

    logic mclk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   exp_clips = 0;

    always #5 mclk = ~mclk;

    audio_mixer_n_if #(.NUM_CH(NCH), .SAMPLE_BITS(SB), .VOLUME_BITS(VB),
                       .MASTER_VOL_BITS(MVB), .BUF_LEN(BL)) bif ();

    audio_mixer_n #(.NUM_CH(NCH), .SAMPLE_BITS(SB), .VOLUME_BITS(VB),
                    .MASTER_VOL_BITS(MVB), .BUF_LEN(BL)) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bif)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Reference: gains as fractions vol/2^VB and (mv+1)/2^MVB with floor rounding, then clamp
    function automatic vec_t model(input vec_t v);
        longint acc, m, hi, lo;
        vec_t r;
        r = v;
        acc = 0;
        for (int k = 0; k < NCH; k++) begin
            if (!v.mute[k]) acc += longint'($signed(v.s[k])) * longint'(v.v[k]);
        end
        m  = fdiv(fdiv(acc, longint'(2) ** VB) * (longint'(v.mv) + 1), longint'(2) ** MVB);
        hi = (longint'(2) ** (SB - 1)) - 1;
        lo = -(longint'(2) ** (SB - 1));
        r.exp_clip = (m > hi) || (m < lo);
        if (m > hi) m = hi;
        if (m < lo) m = lo;
        r.exp_data = SB'(m);
        return r;
    endfunction

    function automatic vec_t one_ch(input int s, input int vol, input bit mute, input int mv,
                                    input int pidx, input int exp, input bit clip);
        vec_t v;
        v = '0;
        v.s[0]     = SB'(s);
        v.v[0]     = VB'(vol);
        v.mute[0]  = mute;
        v.mv       = MVB'(mv);
        v.pidx     = 8'(pidx);
        v.exp_data = SB'(exp);
        v.exp_clip = clip;
        return v;
    endfunction

    function automatic vec_t all_ch(input int s, input int vol, input int mv, input int pidx,
                                    input int exp, input bit clip);
        vec_t v;
        v = '0;
        for (int k = 0; k < NCH; k++) begin
            v.s[k] = SB'(s);
            v.v[k] = VB'(vol);
        end
        v.mv       = MVB'(mv);
        v.pidx     = 8'(pidx);
        v.exp_data = SB'(exp);
        v.exp_clip = clip;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bif.ch_sample  = v.s;
        bif.ch_vol     = v.v;
        bif.ch_mute    = v.mute;
        bif.master_vol = v.mv;
        bif.play_index = v.pidx;
    endtask

    task automatic scramble();
        bif.ch_sample  = {$urandom, $urandom, $urandom};
        bif.ch_vol     = {$urandom, $urandom};
        bif.ch_mute    = NCH'($urandom);
        bif.master_vol = MVB'($urandom);
        bif.play_index = 8'($urandom);
    endtask

    // One full mix: fall at cycle 0, expect a single wr_en at cycle 7
    task automatic run_mix(input vec_t v, input bit perturb, input string tag);
        int  lat;
        bit  seen;
        logic [7:0] ea;
        seen = 1'b0;
        ea   = v.pidx - 8'd1;
        @(posedge mclk); #1; bif.lrclk = 1'b1; drive(v);
        @(posedge mclk); #1; bif.lrclk = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
            @(posedge mclk);
            if (perturb && lat == 2) begin #1; scramble(); end
            @(negedge mclk);
            if (lat == 1) chk({tag, " busy"}, bif.busy, 1);
            if (bif.wr_en) begin seen = 1'b1; break; end
        end
        chk({tag, " latency"}, seen ? lat : -1, 7);
        if (seen) begin
            chk({tag, " wr_data"}, $signed(bif.wr_data), v.exp_data);
            chk({tag, " wr_addr"}, bif.wr_addr, ea);
            chk({tag, " clip"}, bif.clip, v.exp_clip);
            if (v.exp_clip) exp_clips++;
        end
        @(posedge mclk); #1; bif.lrclk = 1'b1;
        @(negedge mclk);
        chk({tag, " wr_en_drop"}, bif.wr_en, 0);
        chk({tag, " busy_drop"}, bif.busy, 0);
    endtask

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   pulses;
        rst = 1'b1;
        bif.lrclk = 1'b1;
        drive('0);
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        chk("rst wr_en", bif.wr_en, 0);
        chk("rst wr_addr", bif.wr_addr, 0);
        chk("rst wr_data", bif.wr_data, 0);
        chk("rst busy", bif.busy, 0);
        chk("rst clip", bif.clip, 0);
        chk("rst overrun", bif.overrun, 0);
        chk("rst clip_count", bif.clip_count, 0);
        @(posedge mclk); #1; rst = 1'b0;

        tbl[0] = one_ch(1000, 128, 1'b0, 15, 0, 500, 1'b0);
        tbl[1] = one_ch(1000, 128, 1'b0, 7, 0, 250, 1'b0);
        tbl[2] = one_ch(1000, 128, 1'b1, 7, 0, 0, 1'b0);
        tbl[3] = all_ch(32767, 255, 15, 10, 32767, 1'b1);
        tbl[4] = all_ch(-32768, 255, 15, 200, -32768, 1'b1);
        tbl[5] = one_ch(-1, 1, 1'b0, 15, 1, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_mix(tbl[i], 1'b0, $sformatf("vec%0d", i));
            if (i == 4) chk("clip_count after clips", bif.clip_count, STATS ? 2 : 0);
        end

        // Inputs scrambled at cycle 2 must not leak into the result
        run_mix(tbl[5], 1'b1, "snapshot");

        for (int n = 0; n < 40; n++) begin
            v = '0;
            for (int k = 0; k < NCH; k++) begin
                v.s[k] = ($urandom_range(0, 3) == 0) ? SB'(32767 - $urandom_range(0, 3)) : SB'($urandom);
                v.v[k] = VB'($urandom);
            end
            v.mute = NCH'($urandom);
            v.mv   = MVB'($urandom);
            v.pidx = 8'($urandom);
            v = model(v);
            run_mix(v, n[0], $sformatf("rand%0d", n));
        end
        chk("clip_count random", bif.clip_count, STATS ? ((exp_clips > 65535) ? 65535 : exp_clips) : 0);

        // Second fall three cycles into a mix
        chk("overrun before", bif.overrun, 0);
        @(posedge mclk); #1; bif.lrclk = 1'b1; drive(tbl[0]);
        @(posedge mclk); #1; bif.lrclk = 1'b0;
        @(posedge mclk); #1;
        @(posedge mclk); #1; bif.lrclk = 1'b1;
        @(posedge mclk); #1; bif.lrclk = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge mclk);
            if (bif.wr_en) pulses++;
        end
        chk("overrun pulses", pulses, 1);
        chk("overrun set", bif.overrun, 1);
        run_mix(tbl[1], 1'b0, "after_ovr");
        chk("overrun sticky", bif.overrun, 1);

        // Reset at cycle 4 of a mix
        @(posedge mclk); #1; bif.lrclk = 1'b1; drive(tbl[0]);
        @(posedge mclk); #1; bif.lrclk = 1'b0;
        repeat (4) @(posedge mclk);
        #1; rst = 1'b1; bif.lrclk = 1'b1;
        #1;
        chk("midrst busy", bif.busy, 0);
        chk("midrst wr_en", bif.wr_en, 0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge mclk);
            if (bif.wr_en) pulses++;
        end
        chk("midrst no write", pulses, 0);
        chk("midrst overrun", bif.overrun, 0);
        chk("midrst clip_count", bif.clip_count, 0);
        exp_clips = 0;
        @(posedge mclk); #1; rst = 1'b0;
        run_mix(tbl[0], 1'b0, "post_rst");
        run_mix(tbl[3], 1'b0, "post_rst_clip");
        chk("clip_count post_rst", bif.clip_count, STATS ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_mixer_n.md
# audio_mixer_n

Parametrised N-channel audio mixer that replaces the fixed five-source summation feeding the master I2S sample buffer. On each falling edge of the I2S LR clock it snapshots every source sample and its per-channel volume. It then accumulates them through one time-shared multiplier, applies a master volume and saturates to sample width. The result is written into the master playback buffer one slot behind the player's current read index.

## Interface
Parameters:
- NUM_CH, 5: number of source channels (1..16).
- SAMPLE_BITS, 16: signed sample width, in and out.
- VOLUME_BITS, 8: unsigned per-channel volume width.
- MASTER_VOL_BITS, 4: unsigned master volume width.
- BUF_LEN, 256: master buffer depth (power of two); INDEX_BITS = $clog2(BUF_LEN).

Ports:
- mclk, input, 1: audio master clock; the only clock.
- rst, input, 1: asynchronous, active-high reset.
- lrclk, input, 1: I2S LR clock, synchronous to mclk.
- ch_sample, input, NUM_CH*SAMPLE_BITS: signed samples; channel k at [k*SAMPLE_BITS +: SAMPLE_BITS].
- ch_vol, input, NUM_CH*VOLUME_BITS: unsigned per-channel gain, same packing.
- ch_mute, input, NUM_CH: 1 forces that channel's contribution to 0.
- master_vol, input, MASTER_VOL_BITS: master gain code.
- play_index, input, INDEX_BITS: player's current read index.
- wr_en, output, 1: single-cycle buffer write strobe.
- wr_addr, output, INDEX_BITS: buffer write address.
- wr_data, output, SAMPLE_BITS: mixed, saturated sample.
- busy, output, 1: high while a mix is in progress.
- clip, output, 1: pulse with wr_en when wr_data was saturated.
- overrun, output, 1: sticky; an lrclk falling edge arrived while busy. Cleared only by rst.
- clip_count, output, 16: see Configuration.

## Operation
- Edge detect: lrclk_q is registered each cycle. fall = lrclk_q & ~lrclk.
- States:
  - IDLE: on fall, snapshot ch_sample, ch_vol, ch_mute, master_vol and play_index; clear acc and ch_cnt; go to ACCUM.
  - ACCUM: each cycle, acc += muted ? 0 : sample[ch_cnt] * {1'b0, vol[ch_cnt]} (signed). Increment ch_cnt. After channel NUM_CH-1, go to SCALE.
  - SCALE: mixed = (acc >>> VOLUME_BITS) * (master_vol + 1) >>> MASTER_VOL_BITS, using arithmetic (floor) shifts. Saturate to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1]. Go to WRITE.
  - WRITE: assert wr_en, wr_data and clip. wr_addr = (snapshot play_index - 1) mod BUF_LEN, so index 0 maps to BUF_LEN-1. Go to IDLE.
- Width: acc is SAMPLE_BITS + VOLUME_BITS + 1 + $clog2(NUM_CH) bits. No intermediate overflow is permitted; saturation happens only in SCALE.
- Gain: channel gain is vol/2^VOLUME_BITS. Master gain is (master_vol+1)/2^MASTER_VOL_BITS, so the maximum master code is exact unity.
- busy is high in ACCUM, SCALE and WRITE.
- A fall while busy is dropped: no restart, no second write, overrun set.
- Inputs changing after the snapshot do not affect the current mix.

## Timing
- Cycle 0: fall observed, snapshot taken.
- Cycles 1..NUM_CH: ACCUM.
- Cycle NUM_CH+1: SCALE.
- Cycle NUM_CH+2: WRITE. wr_en is high for exactly this one cycle; write latency is NUM_CH+2 cycles after the fall.
- wr_addr, wr_data and clip are registered. They hold their last value outside WRITE and are meaningful only when wr_en=1.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, clip=0, overrun=0, clip_count=0, lrclk_q=1, state IDLE.
- Reset mid-mix aborts immediately with no write. The first fall after reset release starts a fresh mix.
- The minimum lrclk period is NUM_CH+3 mclk cycles; shorter periods cause overrun.

## Configuration
- MIXER_CLIP_STATS_EN defined: clip_count is a 16-bit counter that increments on every write with clip=1. It saturates at 0xFFFF and resets to 0.
- MIXER_CLIP_STATS_EN undefined: no counter logic is built and clip_count is tied to 0. The clip pulse still operates.

## Test plan
- NUM_CH=5, ch0=1000, vol0=128, others vol 0, master_vol=15, play_index=0, lrclk falls -> one wr_en pulse exactly 7 cycles later with wr_addr=255, wr_data=500, clip=0.
- Same stimulus with master_vol=7 -> wr_data=250. Then set ch_mute[0]=1 -> wr_data=0.
- All channels at 32767 with vol 255 -> wr_data=32767, clip=1. All channels at -32768 with vol 255 -> wr_data=-32768, clip=1. With MIXER_CLIP_STATS_EN defined, clip_count=2.
- ch0=-1, vol0=1, master_vol=15 -> wr_data=-1 (floor shift). Changing ch0 to 5000 at cycle 2 leaves the result at -1 (snapshot holds).
- Second lrclk fall 3 cycles after the first -> only one wr_en pulse and overrun=1. overrun stays 1 until rst.
- Assert rst at cycle 4 of a mix -> no wr_en and busy=0 immediately. After release, the next fall produces a correct write 7 cycles later.
